// File: rtl/packet_receiver.sv
// packet_receiver: receive-side endpoint of the transmitter packet stream.
// Parses dstid/srcid/size, checks framing, length and (optionally) parity,
// and buffers accepted payload in a show-ahead FIFO for a downstream reader.
//
// Optional feature macro: RX_PARITY_CHECK_EN (parity byte compared against the
// running XOR of the packet; when undefined the parity byte only terminates).
//
// Ports:
//   write_clk_tb        clock, rising edge
//   rst_tb              asynchronous active-high reset
//   pkt_in/pkt_valid/pkt_start/pkt_end   input byte stream
//   stop_packet         registered backpressure (free entries < STOP_THRESH)
//   rx_data/rx_valid/rx_ready            FIFO read side, show-ahead
//   hdr_dst/hdr_src/hdr_len              header of last completed packet
//   pkt_done/pkt_drop/pkt_err            one-cycle completion pulses
//   err_code            {parity, length, framing}, held until next pkt_err
//   overflow            sticky FIFO overflow flag
module packet_receiver #(
  parameter logic [7:0] ADDR        = 8'hA,
  parameter int         DEPTH       = 16,
  parameter int         STOP_THRESH = 8
) (
  input  logic       write_clk_tb,
  input  logic       rst_tb,
  input  logic [7:0] pkt_in,
  input  logic       pkt_valid,
  input  logic       pkt_start,
  input  logic       pkt_end,
  output logic       stop_packet,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] hdr_dst,
  output logic [7:0] hdr_src,
  output logic [2:0] hdr_len,
  output logic       pkt_done,
  output logic       pkt_drop,
  output logic       pkt_err,
  output logic [2:0] err_code,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_W = (AW+1)'(STOP_THRESH);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SRC     = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    PARITY  = 3'd4
  } state_t;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [7:0]  dst_r;
  logic [7:0]  src_r;
  logic [2:0]  len_r;
  logic        accept_r;
  logic        skip_r;      // swallow stray bytes after a missing-end error
  logic        ovf_pkt_r;   // current packet lost a byte to a full FIFO

  logic [7:0]  hdr_dst_r;
  logic [7:0]  hdr_src_r;
  logic [2:0]  hdr_len_r;
  logic        pkt_done_r;
  logic        pkt_drop_r;
  logic        pkt_err_r;
  logic [2:0]  err_code_r;
  logic        overflow_r;

  logic [7:0]  mem_r [DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic [7:0]  rx_data_r;
  logic        rx_valid_r;
  logic        stop_r;

  logic        push_req_s;
  logic        pop_s;
  logic        full_s;
  logic        push_s;
  logic        ovf_s;
  logic [AW:0] occ_s;
  logic [AW:0] wr_nxt_s;
  logic [AW:0] rd_nxt_s;
  logic [AW:0] occ_nxt_s;
  logic [7:0]  data_nxt_s;
  logic        par_err_s;
  logic [2:0]  end_code_s;

`ifdef RX_PARITY_CHECK_EN
  logic [7:0]  xor_r;

  function automatic logic [7:0] acc_parity(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // Running XOR of every byte from dstid up to (not including) the parity byte.
  always_ff @(posedge write_clk_tb or posedge rst_tb) begin
    if (rst_tb) begin
      xor_r <= 8'h00;
    end else if (pkt_valid && pkt_start) begin
      xor_r <= pkt_in;
    end else if (pkt_valid && (state_r == SRC || state_r == LEN || state_r == PAYLOAD)) begin
      xor_r <= acc_parity(xor_r, pkt_in);
    end
  end

  assign par_err_s = (pkt_in != xor_r);
`else
  assign par_err_s = 1'b0;
`endif

  // FIFO push/pop decisions; a pop on a full FIFO frees room for the push.
  always_comb begin
    push_req_s = pkt_valid && !pkt_start && !pkt_end && (state_r == PAYLOAD) && accept_r;
    pop_s      = rx_valid_r && rx_ready;
    occ_s      = wr_ptr_r - rd_ptr_r;
    full_s     = (occ_s == FULL_CNT);
    push_s     = push_req_s && (!full_s || pop_s);
    ovf_s      = push_req_s && full_s && !pop_s;
    wr_nxt_s   = wr_ptr_r + {{AW{1'b0}}, push_s};
    rd_nxt_s   = rd_ptr_r + {{AW{1'b0}}, pop_s};
    occ_nxt_s  = wr_nxt_s - rd_nxt_s;
    end_code_s = {par_err_s, ovf_pkt_r, 1'b0};
  end

  // Next head byte: zero when empty, the incoming byte when it lands on the head slot.
  always_comb begin
    if (wr_nxt_s == rd_nxt_s) begin
      data_nxt_s = 8'h00;
    end else if (push_s && (wr_ptr_r == rd_nxt_s)) begin
      data_nxt_s = pkt_in;
    end else begin
      data_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge write_clk_tb) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= pkt_in;
    end
  end

  // FIFO pointers and registered read-side/backpressure outputs.
  always_ff @(posedge write_clk_tb or posedge rst_tb) begin
    if (rst_tb) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_nxt_s;
      rd_ptr_r   <= rd_nxt_s;
      rx_data_r  <= data_nxt_s;
      rx_valid_r <= (wr_nxt_s != rd_nxt_s);
      stop_r     <= ((FULL_CNT - occ_nxt_s) < THRESH_W);
    end
  end

  // Packet parser FSM with registered status outputs.
  always_ff @(posedge write_clk_tb or posedge rst_tb) begin
    if (rst_tb) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      dst_r      <= 8'h00;
      src_r      <= 8'h00;
      len_r      <= 3'd0;
      accept_r   <= 1'b0;
      skip_r     <= 1'b0;
      ovf_pkt_r  <= 1'b0;
      hdr_dst_r  <= 8'h00;
      hdr_src_r  <= 8'h00;
      hdr_len_r  <= 3'd0;
      pkt_done_r <= 1'b0;
      pkt_drop_r <= 1'b0;
      pkt_err_r  <= 1'b0;
      err_code_r <= 3'b000;
      overflow_r <= 1'b0;
    end else begin
      pkt_done_r <= 1'b0;
      pkt_drop_r <= 1'b0;
      pkt_err_r  <= 1'b0;
      if (ovf_s) begin
        overflow_r <= 1'b1;
        ovf_pkt_r  <= 1'b1;
      end
      if (pkt_valid) begin
        if (pkt_start) begin
          // A start anywhere but IDLE aborts the current packet.
          if (state_r != IDLE) begin
            pkt_err_r  <= 1'b1;
            err_code_r <= 3'b001;
          end
          dst_r     <= pkt_in;
          accept_r  <= (pkt_in == ADDR) || (pkt_in == 8'hFF);
          ovf_pkt_r <= 1'b0;
          skip_r    <= 1'b0;
          state_r   <= SRC;
        end else begin
          case (state_r)
            IDLE: begin
              if (!skip_r) begin
                pkt_err_r  <= 1'b1;
                err_code_r <= 3'b001;
              end
            end
            SRC, LEN, PAYLOAD: begin
              if (pkt_end) begin
                pkt_err_r  <= 1'b1;
                err_code_r <= 3'b010;
                state_r    <= IDLE;
              end else if (state_r == SRC) begin
                src_r   <= pkt_in;
                state_r <= LEN;
              end else if (state_r == LEN) begin
                len_r   <= pkt_in[2:0];
                cnt_r   <= pkt_in[2:0];
                state_r <= (pkt_in[2:0] == 3'd0) ? PARITY : PAYLOAD;
              end else begin
                cnt_r <= cnt_r - 3'd1;
                if (cnt_r == 3'd1) begin
                  state_r <= PARITY;
                end
              end
            end
            PARITY: begin
              state_r <= IDLE;
              if (!pkt_end) begin
                pkt_err_r  <= 1'b1;
                err_code_r <= 3'b010;
                skip_r     <= 1'b1;
              end else if (end_code_s != 3'b000) begin
                pkt_err_r  <= 1'b1;
                err_code_r <= end_code_s;
              end else begin
                pkt_done_r <= accept_r;
                pkt_drop_r <= !accept_r;
                hdr_dst_r  <= dst_r;
                hdr_src_r  <= src_r;
                hdr_len_r  <= len_r;
              end
            end
            default: state_r <= IDLE;
          endcase
        end
      end
    end
  end

  assign stop_packet = stop_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign hdr_dst     = hdr_dst_r;
  assign hdr_src     = hdr_src_r;
  assign hdr_len     = hdr_len_r;
  assign pkt_done    = pkt_done_r;
  assign pkt_drop    = pkt_drop_r;
  assign pkt_err     = pkt_err_r;
  assign err_code    = err_code_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_packet_receiver.sv
// Directed self-checking bench for packet_receiver (default parameters).
module tb_packet_receiver;

  logic       write_clk_tb = 1'b0;
  logic       rst_tb       = 1'b1;
  logic [7:0] pkt_in       = 8'h00;
  logic       pkt_valid    = 1'b0;
  logic       pkt_start    = 1'b0;
  logic       pkt_end      = 1'b0;
  logic       rx_ready     = 1'b0;
  logic       stop_packet;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] hdr_dst;
  logic [7:0] hdr_src;
  logic [2:0] hdr_len;
  logic       pkt_done;
  logic       pkt_drop;
  logic       pkt_err;
  logic [2:0] err_code;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  packet_receiver dut (
    .write_clk_tb(write_clk_tb), .rst_tb(rst_tb),
    .pkt_in(pkt_in), .pkt_valid(pkt_valid), .pkt_start(pkt_start), .pkt_end(pkt_end),
    .stop_packet(stop_packet), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_len(hdr_len),
    .pkt_done(pkt_done), .pkt_drop(pkt_drop), .pkt_err(pkt_err),
    .err_code(err_code), .overflow(overflow)
  );

  always #5 write_clk_tb = ~write_clk_tb;

  // Pulse counters: a pulse raised at edge N is still high when edge N+1 samples it.
  always @(posedge write_clk_tb) begin
    if (pkt_done) done_cnt <= done_cnt + 1;
    if (pkt_err)  err_cnt  <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic byte_in(input logic [7:0] b, input logic s, input logic e);
    pkt_in = b; pkt_start = s; pkt_end = e; pkt_valid = 1'b1;
    @(negedge write_clk_tb);
  endtask

  task automatic idle();
    pkt_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0;
    @(negedge write_clk_tb);
  endtask

  // Sends a full packet; payload bytes are base+1 .. base+size.
  task automatic send_pkt(input logic [7:0] dst, input logic [7:0] src, input logic [2:0] size,
                          input logic [7:0] base, input logic [7:0] flip);
    logic [7:0] p;
    logic [7:0] b;
    p = dst ^ src ^ {5'b00000, size};
    byte_in(dst, 1'b1, 1'b0);
    byte_in(src, 1'b0, 1'b0);
    byte_in({5'b00000, size}, 1'b0, 1'b0);
    for (int i = 1; i <= int'(size); i++) begin
      b = base + 8'(i);
      p = p ^ b;
      byte_in(b, 1'b0, 1'b0);
    end
    byte_in(p ^ flip, 1'b0, 1'b1);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq({tag, "_valid"}, {31'd0, rx_valid}, 32'd1);
    check_eq({tag, "_data"}, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    @(negedge write_clk_tb);
    rx_ready = 1'b0;
  endtask

  initial begin
    int d0;
    int e0;
    logic [7:0] p;
    repeat (3) @(negedge write_clk_tb);
    // Reset state
    check_eq("rst_stop", {31'd0, stop_packet}, 32'd0);
    check_eq("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("rst_hdr", {13'd0, hdr_dst, hdr_src, hdr_len}, 32'd0);
    check_eq("rst_pulses", {29'd0, pkt_done, pkt_drop, pkt_err}, 32'd0);
    check_eq("rst_err_code", {29'd0, err_code}, 32'd0);
    check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
    rst_tb = 1'b0;
    @(negedge write_clk_tb);

    // 1: own address, size 5, good parity
    send_pkt(8'h0A, 8'h0A, 3'd5, 8'h00, 8'h00);
    check_eq("t1_done", {31'd0, pkt_done}, 32'd1);
    check_eq("t1_err", {31'd0, pkt_err}, 32'd0);
    check_eq("t1_hdr_len", {29'd0, hdr_len}, 32'd5);
    check_eq("t1_hdr_dst", {24'd0, hdr_dst}, 32'h0A);
    check_eq("t1_err_code", {29'd0, err_code}, 32'd0);
    idle();
    check_eq("t1_done_pulse", {31'd0, pkt_done}, 32'd0);
    for (int i = 1; i <= 5; i++) pop_check("t1_pop", 8'(i));
    check_eq("t1_empty", {31'd0, rx_valid}, 32'd0);

    // 2: foreign address is dropped
    d0 = done_cnt;
    send_pkt(8'h82, 8'h0A, 3'd7, 8'h80, 8'h00);
    check_eq("t2_drop", {31'd0, pkt_drop}, 32'd1);
    check_eq("t2_done", {31'd0, pkt_done}, 32'd0);
    check_eq("t2_hdr_dst", {24'd0, hdr_dst}, 32'h82);
    check_eq("t2_hdr_len", {29'd0, hdr_len}, 32'd7);
    idle();
    check_eq("t2_fifo", {31'd0, rx_valid}, 32'd0);
    check_eq("t2_done_cnt", done_cnt - d0, 32'd0);

    // 3: broadcast with corrupted parity
    send_pkt(8'hFF, 8'h33, 3'd3, 8'h10, 8'h5A);
`ifdef RX_PARITY_CHECK_EN
    check_eq("t3_err", {31'd0, pkt_err}, 32'd1);
    check_eq("t3_err_code", {29'd0, err_code}, 32'd4);
    check_eq("t3_done", {31'd0, pkt_done}, 32'd0);
`else
    check_eq("t3_done", {31'd0, pkt_done}, 32'd1);
    check_eq("t3_err_code", {29'd0, err_code}, 32'd0);
    check_eq("t3_hdr_src", {24'd0, hdr_src}, 32'h33);
`endif
    idle();
    for (int i = 1; i <= 3; i++) pop_check("t3_pop", 8'h10 + 8'(i));

    // 4: start reasserted inside a size-6 payload
    d0 = done_cnt;
    e0 = err_cnt;
    byte_in(8'h0A, 1'b1, 1'b0);
    byte_in(8'h01, 1'b0, 1'b0);
    byte_in(8'h06, 1'b0, 1'b0);
    byte_in(8'h21, 1'b0, 1'b0);
    byte_in(8'h22, 1'b0, 1'b0);
    send_pkt(8'h0A, 8'h02, 3'd2, 8'h30, 8'h00);
    check_eq("t4_done", {31'd0, pkt_done}, 32'd1);
    check_eq("t4_hdr_src", {24'd0, hdr_src}, 32'h02);
    check_eq("t4_hdr_len", {29'd0, hdr_len}, 32'd2);
    check_eq("t4_err_code", {29'd0, err_code}, 32'd1);
    idle();
    check_eq("t4_done_cnt", done_cnt - d0, 32'd1);
    check_eq("t4_err_cnt", err_cnt - e0, 32'd1);
    pop_check("t4_pop", 8'h21);
    pop_check("t4_pop", 8'h22);
    pop_check("t4_pop", 8'h31);
    pop_check("t4_pop", 8'h32);
    check_eq("t4_empty", {31'd0, rx_valid}, 32'd0);

    // 5: fill, backpressure threshold, overflow, drain
    send_pkt(8'h0A, 8'h05, 3'd7, 8'h60, 8'h00);
    idle();
    check_eq("t5_stop_occ7", {31'd0, stop_packet}, 32'd0);
    p = 8'h0A ^ 8'h05 ^ 8'h07;
    byte_in(8'h0A, 1'b1, 1'b0);
    byte_in(8'h05, 1'b0, 1'b0);
    byte_in(8'h07, 1'b0, 1'b0);
    for (int i = 1; i <= 7; i++) begin
      p = p ^ (8'h40 + 8'(i));
      byte_in(8'h40 + 8'(i), 1'b0, 1'b0);
      if (i == 1) check_eq("t5_stop_occ8", {31'd0, stop_packet}, 32'd0);
      if (i == 2) check_eq("t5_stop_occ9", {31'd0, stop_packet}, 32'd1);
    end
    byte_in(p, 1'b0, 1'b1);
    check_eq("t5_done2", {31'd0, pkt_done}, 32'd1);
    idle();
    send_pkt(8'h0A, 8'h05, 3'd7, 8'h50, 8'h00);
    check_eq("t5_ovf_err", {31'd0, pkt_err}, 32'd1);
    check_eq("t5_ovf_code", {29'd0, err_code}, 32'd2);
    check_eq("t5_overflow", {31'd0, overflow}, 32'd1);
    check_eq("t5_ovf_done", {31'd0, pkt_done}, 32'd0);
    idle();
    check_eq("t5_stop_full", {31'd0, stop_packet}, 32'd1);
    for (int i = 1; i <= 7; i++) pop_check("t5_pop_a", 8'h60 + 8'(i));
    check_eq("t5_stop_occ9b", {31'd0, stop_packet}, 32'd1);
    pop_check("t5_pop_b", 8'h41);
    check_eq("t5_stop_occ8b", {31'd0, stop_packet}, 32'd0);
    for (int i = 2; i <= 7; i++) pop_check("t5_pop_b", 8'h40 + 8'(i));
    pop_check("t5_pop_c", 8'h51);
    pop_check("t5_pop_c", 8'h52);
    check_eq("t5_drained", {31'd0, rx_valid}, 32'd0);
    check_eq("t5_sticky", {31'd0, overflow}, 32'd1);

    // 6: reset mid-packet then a clean packet
    byte_in(8'h0A, 1'b1, 1'b0);
    byte_in(8'h01, 1'b0, 1'b0);
    byte_in(8'h03, 1'b0, 1'b0);
    byte_in(8'h71, 1'b0, 1'b0);
    pkt_valid = 1'b0; pkt_start = 1'b0; pkt_end = 1'b0;
    rst_tb = 1'b1;
    #1;
    check_eq("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    check_eq("t6_rst_err_code", {29'd0, err_code}, 32'd0);
    check_eq("t6_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("t6_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check_eq("t6_rst_hdr", {13'd0, hdr_dst, hdr_src, hdr_len}, 32'd0);
    check_eq("t6_rst_stop", {31'd0, stop_packet}, 32'd0);
    @(negedge write_clk_tb);
    rst_tb = 1'b0;
    @(negedge write_clk_tb);
    send_pkt(8'hFF, 8'h09, 3'd1, 8'h70, 8'h00);
    check_eq("t6_done", {31'd0, pkt_done}, 32'd1);
    check_eq("t6_hdr_dst", {24'd0, hdr_dst}, 32'hFF);
    check_eq("t6_hdr_len", {29'd0, hdr_len}, 32'd1);
    check_eq("t6_err_code", {29'd0, err_code}, 32'd0);
    idle();
    pop_check("t6_pop", 8'h71);
    check_eq("t6_empty", {31'd0, rx_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
